belief_propagation_control_path: RTL and testbench

Moore state-machine sequencer for the 3×6 LDPC belief-propagation decoder; it pairs with the data path, which holds the message matrix, row/column processing units, sum vector and iteration counter. On `start` it initialises the message matrix from the received vector. It then runs alternating row-processing and column-processing passes and updates the sum vector after each pass pair. It stops when the data path reports `done_iterations`.

---
 rtl/bp_pkg.sv | 24 ++
 rtl/bp_done_collector.sv | 29 ++
 rtl/belief_propagation_control_path.sv | 129 ++++++++++++
 tb/tb_belief_propagation_control_path.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared definitions for the 3x6 LDPC belief-propagation control path:
// sequencer states, matrix geometry and matrix-input select encodings.
package bp_pkg;

    localparam int BP_ROWS = 3;
    localparam int BP_COLS = 6;

    localparam logic SEL_ROW = 1'b0;
    localparam logic SEL_COL = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INIT,
        ST_ROW_START,
        ST_ROW_WAIT,
        ST_ROW_LOAD,
        ST_COL_START,
        ST_COL_WAIT,
        ST_COL_LOAD,
        ST_CHECK,
        ST_DONE
    } bp_state_t;

endpackage

// File: rtl/bp_done_collector.sv
// Sticky collector of per-unit done flags; a flag arriving in the clear
// cycle survives the clear so a fast unit is never lost.
module bp_done_collector #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic [N-1:0] done_in,
    output logic         all_done
);

    logic [N-1:0] r_flags;
    logic [N-1:0] w_flags;

    // all_done includes this cycle's inputs so the WAIT state can leave
    // in the same cycle the last unit reports.
    assign w_flags  = (clear ? '0 : r_flags) | done_in;
    assign all_done = &w_flags;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flags <= '0;
        end else begin
            r_flags <= w_flags;
        end
    end

endmodule

// File: rtl/belief_propagation_control_path.sv
// Moore sequencer for the 3x6 LDPC belief-propagation decoder: init, then
// alternating row/column passes until the data path reports done_iterations.
module belief_propagation_control_path
    import bp_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic done,
    output logic start_row_processing,
    output logic start_column_processing,
    input  logic done_row_processing_row_1,
    input  logic done_row_processing_row_2,
    input  logic done_row_processing_row_3,
    input  logic done_column_processing_column_1,
    input  logic done_column_processing_column_2,
    input  logic done_column_processing_column_3,
    input  logic done_column_processing_column_4,
    input  logic done_column_processing_column_5,
    input  logic done_column_processing_column_6,
    output logic initialize_parity_check_matrix,
    output logic load_parity_check_matrix,
    output logic select_input_to_parity_check_matrix,
    output logic load_sum_vector,
    output logic reset_count,
    output logic increment_count,
    input  logic done_iterations
);

    bp_state_t r_state;
    bp_state_t w_next;

    logic               w_row_clear;
    logic               w_col_clear;
    logic               w_row_en;
    logic               w_col_en;
    logic [BP_ROWS-1:0] w_row_done;
    logic [BP_COLS-1:0] w_col_done;
    logic               w_rows_all_done;
    logic               w_cols_all_done;

    // Done flags only count during their own START/WAIT window.
    assign w_row_en    = (r_state == ST_ROW_START) || (r_state == ST_ROW_WAIT);
    assign w_col_en    = (r_state == ST_COL_START) || (r_state == ST_COL_WAIT);
    assign w_row_clear = (r_state == ST_INIT) || (r_state == ST_ROW_START);
    assign w_col_clear = (r_state == ST_INIT) || (r_state == ST_COL_START);

    assign w_row_done = {done_row_processing_row_3,
                         done_row_processing_row_2,
                         done_row_processing_row_1} & {BP_ROWS{w_row_en}};

    assign w_col_done = {done_column_processing_column_6,
                         done_column_processing_column_5,
                         done_column_processing_column_4,
                         done_column_processing_column_3,
                         done_column_processing_column_2,
                         done_column_processing_column_1} & {BP_COLS{w_col_en}};

    bp_done_collector #(.N(BP_ROWS)) u_row_collector (
        .clk      (clk),
        .reset    (reset),
        .clear    (w_row_clear),
        .done_in  (w_row_done),
        .all_done (w_rows_all_done)
    );

    bp_done_collector #(.N(BP_COLS)) u_col_collector (
        .clk      (clk),
        .reset    (reset),
        .clear    (w_col_clear),
        .done_in  (w_col_done),
        .all_done (w_cols_all_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:      if (start) w_next = ST_INIT;
            ST_INIT:      w_next = ST_ROW_START;
            ST_ROW_START: w_next = ST_ROW_WAIT;
            ST_ROW_WAIT:  if (w_rows_all_done) w_next = ST_ROW_LOAD;
            ST_ROW_LOAD:  w_next = ST_COL_START;
            ST_COL_START: w_next = ST_COL_WAIT;
            ST_COL_WAIT:  if (w_cols_all_done) w_next = ST_COL_LOAD;
            ST_COL_LOAD:  w_next = ST_CHECK;
            ST_CHECK:     w_next = done_iterations ? ST_DONE : ST_ROW_START;
            ST_DONE:      if (start) w_next = ST_INIT;
            default:      w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        done                                = 1'b0;
        start_row_processing                = 1'b0;
        start_column_processing             = 1'b0;
        initialize_parity_check_matrix      = 1'b0;
        load_parity_check_matrix            = 1'b0;
        select_input_to_parity_check_matrix = SEL_ROW;
        load_sum_vector                     = 1'b0;
        reset_count                         = 1'b0;
        increment_count                     = 1'b0;
        case (r_state)
            ST_INIT: begin
                initialize_parity_check_matrix = 1'b1;
                reset_count                    = 1'b1;
            end
            ST_ROW_START: start_row_processing = 1'b1;
            ST_ROW_LOAD:  load_parity_check_matrix = 1'b1;
            ST_COL_START: start_column_processing = 1'b1;
            ST_COL_LOAD: begin
                load_parity_check_matrix            = 1'b1;
                select_input_to_parity_check_matrix = SEL_COL;
                load_sum_vector                     = 1'b1;
                increment_count                     = 1'b1;
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_belief_propagation_control_path.sv
// Scoreboard bench: each run pushes its expected strobe timeline; a monitor
// compares every change of the output vector against the queue.
module tb_belief_propagation_control_path;
    import bp_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic done, start_row_processing, start_column_processing;
    logic initialize_parity_check_matrix, load_parity_check_matrix;
    logic select_input_to_parity_check_matrix, load_sum_vector;
    logic reset_count, increment_count;
    logic done_iterations = 1'b0;
    logic [2:0] rdone = '0;
    logic [5:0] cdone = '0;

    belief_propagation_control_path dut (
        .clk                                 (clk),
        .reset                               (reset),
        .start                               (start),
        .done                                (done),
        .start_row_processing                (start_row_processing),
        .start_column_processing             (start_column_processing),
        .done_row_processing_row_1           (rdone[0]),
        .done_row_processing_row_2           (rdone[1]),
        .done_row_processing_row_3           (rdone[2]),
        .done_column_processing_column_1     (cdone[0]),
        .done_column_processing_column_2     (cdone[1]),
        .done_column_processing_column_3     (cdone[2]),
        .done_column_processing_column_4     (cdone[3]),
        .done_column_processing_column_5     (cdone[4]),
        .done_column_processing_column_6     (cdone[5]),
        .initialize_parity_check_matrix      (initialize_parity_check_matrix),
        .load_parity_check_matrix            (load_parity_check_matrix),
        .select_input_to_parity_check_matrix (select_input_to_parity_check_matrix),
        .load_sum_vector                     (load_sum_vector),
        .reset_count                         (reset_count),
        .increment_count                     (increment_count),
        .done_iterations                     (done_iterations)
    );

    always #5 clk = ~clk;

    // Output vector: done,init,rstc,srp,load,sel,scp,lsum,inc
    localparam logic [8:0] V_ZERO = 9'b000000000;
    localparam logic [8:0] V_INIT = 9'b011000000;
    localparam logic [8:0] V_SRP  = 9'b000100000;
    localparam logic [8:0] V_LD0  = 9'b000010000;
    localparam logic [8:0] V_SCP  = 9'b000000100;
    localparam logic [8:0] V_LDC  = 9'b000011011;
    localparam logic [8:0] V_DONE = 9'b100000000;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    int         q_cyc[$];
    logic [8:0] q_vec[$];

    int rdly[3] = '{1, 1, 1};
    int cdly[6] = '{1, 1, 1, 1, 1, 1};
    int rcnt[3] = '{-1, -1, -1};
    int ccnt[6] = '{-1, -1, -1, -1, -1, -1};
    int icnt = 0;
    int target = 1;

    bit         mon_en = 1'b0;
    logic [8:0] prev_v = '0;

    function automatic logic [8:0] outv();
        return {done, initialize_parity_check_matrix, reset_count,
                start_row_processing, load_parity_check_matrix,
                select_input_to_parity_check_matrix, start_column_processing,
                load_sum_vector, increment_count};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic push_ev(input int c, input logic [8:0] v);
        q_cyc.push_back(c);
        q_vec.push_back(v);
    endtask

    // mr/mc: cycles from start pulse to last done flag, floored at 1.
    task automatic push_run(input int s, input int n, input int mr, input int mc);
        int t;
        push_ev(s, V_INIT);
        t = s + 1;
        for (int i = 0; i < n; i++) begin
            push_ev(t, V_SRP);
            push_ev(t + 1, V_ZERO);
            push_ev(t + mr + 1, V_LD0);
            push_ev(t + mr + 2, V_SCP);
            push_ev(t + mr + 3, V_ZERO);
            push_ev(t + mr + mc + 3, V_LDC);
            push_ev(t + mr + mc + 4, V_ZERO);
            t = t + mr + mc + 5;
        end
        push_ev(t, V_DONE);
    endtask

    // Monitor: every change of the output vector must match the queue head.
    initial begin
        int         ec;
        logic [8:0] ev;
        logic [8:0] cur;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                cur = outv();
                if (cur != prev_v) begin
                    checks++;
                    if (q_vec.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_event cyc=%0d got %b expected none", cyc, cur);
                    end else begin
                        ec = q_cyc.pop_front();
                        ev = q_vec.pop_front();
                        if (ec != cyc || ev != cur) begin
                            errors++;
                            $display("FAIL event got cyc=%0d vec=%b expected cyc=%0d vec=%b",
                                     cyc, cur, ec, ev);
                        end
                    end
                    prev_v = cur;
                end
            end
        end
    end

    // Responder: row/column units and iteration counter of the data path.
    initial begin
        forever begin
            @(negedge clk);
            rdone = '0;
            cdone = '0;
            if (reset) begin
                for (int k = 0; k < 3; k++) rcnt[k] = -1;
                for (int k = 0; k < 6; k++) ccnt[k] = -1;
            end else begin
                if (start_row_processing) for (int k = 0; k < 3; k++) rcnt[k] = rdly[k];
                if (start_column_processing) for (int k = 0; k < 6; k++) ccnt[k] = cdly[k];
                for (int k = 0; k < 3; k++) begin
                    if (rcnt[k] == 0) begin
                        rdone[k] = 1'b1;
                        rcnt[k]  = -1;
                    end else if (rcnt[k] > 0) rcnt[k]--;
                end
                for (int k = 0; k < 6; k++) begin
                    if (ccnt[k] == 0) begin
                        cdone[k] = 1'b1;
                        ccnt[k]  = -1;
                    end else if (ccnt[k] > 0) ccnt[k]--;
                end
                if (reset_count) icnt = 0;
                if (increment_count) icnt++;
            end
            done_iterations = (icnt >= target);
        end
    end

    task automatic wait_done(input string name);
        int k = 0;
        while (!done && k < 300) begin
            @(negedge clk);
            k++;
        end
        check({name, "_done_seen"}, {31'd0, done}, 32'd1);
        repeat (4) @(negedge clk);
        check({name, "_done_held"}, {31'd0, done}, 32'd1);
        check({name, "_queue_drained"}, q_vec.size(), 32'd0);
    endtask

    task automatic run(input string name, input int n, input int mr, input int mc,
                       input int tgt, input int hold);
        int s;
        target = tgt;
        @(negedge clk);
        start = 1'b1;
        s = cyc + 1;
        push_run(s, n, mr, mc);
        repeat (hold) @(negedge clk);
        start = 1'b0;
        wait_done(name);
    endtask

    initial begin
        int s;
        reset = 1'b1;
        start = 1'b0;
        #1;
        check("reset_outputs", {23'd0, outv()}, 32'd0);
        check("reset_state", {28'd0, dut.r_state}, {28'd0, ST_IDLE});
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_outputs", {23'd0, outv()}, 32'd0);

        // single iteration, done 8 cycles after INIT
        run("single", 1, 1, 1, 1, 1);

        // restart from DONE with staggered unit completion
        rdly = '{1, 4, 2};
        cdly = '{6, 5, 4, 3, 2, 1};
        run("staggered", 1, 4, 6, 1, 1);

        // flags in the same cycle as the start pulse
        rdly = '{0, 1, 0};
        cdly = '{0, 0, 0, 0, 0, 0};
        run("same_cycle", 2, 1, 1, 2, 1);

        // four iterations with start held high into the run
        rdly = '{1, 1, 1};
        cdly = '{1, 1, 1, 1, 1, 1};
        run("four_iter", 4, 1, 1, 4, 3);

        // abort in COL_WAIT, then a normal run from IDLE
        cdly = '{1, 1, 1, 20, 20, 20};
        target = 1;
        @(negedge clk);
        start = 1'b1;
        s = cyc + 1;
        push_ev(s, V_INIT);
        push_ev(s + 1, V_SRP);
        push_ev(s + 2, V_ZERO);
        push_ev(s + 3, V_LD0);
        push_ev(s + 4, V_SCP);
        push_ev(s + 5, V_ZERO);
        @(negedge clk);
        start = 1'b0;
        while (cyc < s + 7) @(negedge clk);
        check("abort_in_col_wait", {28'd0, dut.r_state}, {28'd0, ST_COL_WAIT});
        #2 reset = 1'b1;
        #1;
        check("abort_outputs", {23'd0, outv()}, 32'd0);
        check("abort_state", {28'd0, dut.r_state}, {28'd0, ST_IDLE});
        check("abort_col_flags", {26'd0, dut.u_col_collector.r_flags}, 32'd0);
        check("abort_queue", q_vec.size(), 32'd0);
        @(negedge clk);
        #2 reset = 1'b0;
        cdly = '{1, 1, 1, 1, 1, 1};
        run("after_abort", 1, 1, 1, 1, 1);

        check("final_queue", q_vec.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
